// File: rtl/fifo_out_serializer_if.sv
// Handshake bundle between the upstream 1-entry FIFO, the serializer and the
// downstream beat sink. The serializer takes the master view.
interface fifo_out_serializer_if #(
    parameter int ITEM_W = 768,
    parameter int BEAT_W = 32
);
    logic [ITEM_W-1:0] in_first;
    logic              in_first__RDY;
    logic              in_deq__RDY;
    logic              in_deq__ENA;
    logic              out_enq__RDY;
    logic              out_enq__ENA;
    logic [BEAT_W-1:0] out_enq_v;
    logic              out_last;

    modport master (
        input  in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
        output in_deq__ENA, out_enq__ENA, out_enq_v, out_last
    );

    modport slave (
        output in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
        input  in_deq__ENA, out_enq__ENA, out_enq_v, out_last
    );
endinterface

// File: rtl/fifo_out_serializer.sv
// Splits one wide upstream item into NBEATS narrow beats, LSB-first, with
// back-to-back item loading on the last beat, backpressure hold and abort.
module fifo_out_serializer #(
    parameter int ITEM_W = 768,
    parameter int BEAT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    fifo_out_serializer_if.master io,
    input  logic                  abort,
    output logic                  busy,
    output logic [15:0]           item_count
);
    localparam int NBEATS = ITEM_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state;
    logic [ITEM_W-1:0] sreg;
    logic [CNT_W-1:0]  bcnt;

    logic xfer;
    logic last_xfer;
    logic load;

    assign xfer      = (state == SEND) && io.out_enq__RDY && !abort;
    assign last_xfer = xfer && (bcnt == LAST_BEAT);
    // NOTE: the load term is gated by RST so no dequeue strobe leaks out while
    // the state register is being held in reset.
    assign load      = !RST && io.in_first__RDY && io.in_deq__RDY &&
                       ((state == IDLE) || last_xfer);

    assign io.in_deq__ENA  = load;
    assign io.out_enq__ENA = xfer;
    assign io.out_enq_v    = sreg[BEAT_W-1:0];
    assign io.out_last     = (state == SEND) && (bcnt == LAST_BEAT);
    assign busy            = (state == SEND);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sreg  <= '0;
            bcnt  <= '0;
        end else if (load) begin
            state <= SEND;
            sreg  <= io.in_first;
            bcnt  <= '0;
        end else if ((state == SEND) && abort) begin
            state <= IDLE;
            bcnt  <= '0;
        end else if (last_xfer) begin
            state <= IDLE;
        end else if (xfer) begin
            sreg  <= sreg >> BEAT_W;
            bcnt  <= bcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            item_count <= '0;
        end else if (last_xfer) begin
            item_count <= item_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fifo_out_serializer.sv
// Directed bench: single item, back-to-back, backpressure, abort, async reset
// mid-item, and item_count wrap on a one-beat-per-item instance.
module tb_fifo_out_serializer;
    localparam int ITEM_W = 768;
    localparam int BEAT_W = 32;
    localparam int NB     = ITEM_W / BEAT_W;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RST_W;
    logic        abort;
    logic        abort_w;
    logic        busy;
    logic        busy_w;
    logic [15:0] item_count;
    logic [15:0] item_count_w;

    int checks;
    int failures;

    always #5 CLK = ~CLK;

    fifo_out_serializer_if #(.ITEM_W(ITEM_W), .BEAT_W(BEAT_W)) s_if ();
    fifo_out_serializer_if #(.ITEM_W(32), .BEAT_W(32)) w_if ();

    fifo_out_serializer #(.ITEM_W(ITEM_W), .BEAT_W(BEAT_W)) dut (
        .CLK(CLK), .RST(RST), .io(s_if),
        .abort(abort), .busy(busy), .item_count(item_count)
    );

    fifo_out_serializer #(.ITEM_W(32), .BEAT_W(32)) dut_w (
        .CLK(CLK), .RST(RST_W), .io(w_if),
        .abort(abort_w), .busy(busy_w), .item_count(item_count_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [ITEM_W-1:0] mk_item(input int base);
        logic [ITEM_W-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) r[k*BEAT_W +: BEAT_W] = 32'(base + k);
        return r;
    endfunction

    // Checks beats first..last_k of an item whose word k is base+k, one per cycle.
    task automatic send_beats(input int base, input int first, input int last_k);
        for (int k = first; k <= last_k; k++) begin
            check($sformatf("beat_v_%0x_%0d", base, k), 64'(s_if.out_enq_v), 64'(base + k));
            check($sformatf("beat_ena_%0x_%0d", base, k), 64'(s_if.out_enq__ENA), 64'd1);
            check($sformatf("beat_last_%0x_%0d", base, k), 64'(s_if.out_last), 64'(k == NB - 1));
            check($sformatf("beat_deq_%0x_%0d", base, k), 64'(s_if.in_deq__ENA),
                  64'(s_if.in_first__RDY && s_if.in_deq__RDY && (k == NB - 1)));
            step();
            settle();
        end
    endtask

    initial begin
        int seen;
        int n;
        checks   = 0;
        failures = 0;

        RST     = 1'b1;
        RST_W   = 1'b1;
        abort   = 1'b0;
        abort_w = 1'b0;
        s_if.in_first      = mk_item(0);
        s_if.in_first__RDY = 1'b1;
        s_if.in_deq__RDY   = 1'b1;
        s_if.out_enq__RDY  = 1'b1;
        w_if.in_first      = 32'hA5A5_0000;
        w_if.in_first__RDY = 1'b1;
        w_if.in_deq__RDY   = 1'b1;
        w_if.out_enq__RDY  = 1'b1;

        // Reset state, with an item already offered upstream.
        #3;
        check("rst_deq_ena", 64'(s_if.in_deq__ENA), 64'd0);
        check("rst_out_ena", 64'(s_if.out_enq__ENA), 64'd0);
        check("rst_last", 64'(s_if.out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_v", 64'(s_if.out_enq_v), 64'd0);
        check("rst_count", 64'(item_count), 64'd0);
        step();
        step();
        check("rst_busy_held", 64'(busy), 64'd0);

        // Single item, sink always ready.
        RST = 1'b0;
        settle();
        check("single_deq_ena", 64'(s_if.in_deq__ENA), 64'd1);
        step();
        s_if.in_first__RDY = 1'b0;
        settle();
        check("single_busy", 64'(busy), 64'd1);
        check("single_deq_once", 64'(s_if.in_deq__ENA), 64'd0);
        send_beats(0, 0, NB - 1);
        check("single_idle", 64'(busy), 64'd0);
        check("single_count", 64'(item_count), 64'd1);
        check("single_last_off", 64'(s_if.out_last), 64'd0);

        // Dequeue is never strobed while the upstream cannot dequeue.
        s_if.in_deq__RDY   = 1'b0;
        s_if.in_first__RDY = 1'b1;
        settle();
        check("gate_deq_rdy", 64'(s_if.in_deq__ENA), 64'd0);
        step();
        check("gate_no_load", 64'(busy), 64'd0);

        // Abort in IDLE does not block a load; then A and B back-to-back.
        s_if.in_deq__RDY = 1'b1;
        abort = 1'b1;
        settle();
        check("idle_abort_load", 64'(s_if.in_deq__ENA), 64'd1);
        step();
        abort = 1'b0;
        s_if.in_first = mk_item(32'h100);
        settle();
        check("b2b_busy", 64'(busy), 64'd1);
        send_beats(0, 0, NB - 1);
        s_if.in_first__RDY = 1'b0;
        settle();
        check("b2b_busy_b", 64'(busy), 64'd1);
        check("b2b_count_a", 64'(item_count), 64'd2);
        send_beats(32'h100, 0, NB - 1);
        check("b2b_count_b", 64'(item_count), 64'd3);
        check("b2b_idle", 64'(busy), 64'd0);

        // Backpressure for 5 cycles at beat 3.
        s_if.in_first      = mk_item(32'h200);
        s_if.in_first__RDY = 1'b1;
        settle();
        step();
        s_if.in_first__RDY = 1'b0;
        settle();
        send_beats(32'h200, 0, 2);
        s_if.out_enq__RDY = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_v_%0d", i), 64'(s_if.out_enq_v), 64'h203);
            check($sformatf("bp_ena_%0d", i), 64'(s_if.out_enq__ENA), 64'd0);
            check($sformatf("bp_busy_%0d", i), 64'(busy), 64'd1);
            step();
            settle();
        end
        s_if.out_enq__RDY = 1'b1;
        settle();
        send_beats(32'h200, 3, NB - 1);
        check("bp_count", 64'(item_count), 64'd4);

        // Abort at beat 10 with B waiting upstream.
        s_if.in_first      = mk_item(0);
        s_if.in_first__RDY = 1'b1;
        settle();
        step();
        s_if.in_first = mk_item(32'h100);
        settle();
        send_beats(0, 0, 9);
        abort = 1'b1;
        settle();
        check("abort_no_xfer", 64'(s_if.out_enq__ENA), 64'd0);
        check("abort_no_load", 64'(s_if.in_deq__ENA), 64'd0);
        check("abort_busy_before", 64'(busy), 64'd1);
        step();
        abort = 1'b0;
        settle();
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_count", 64'(item_count), 64'd4);
        check("abort_reload", 64'(s_if.in_deq__ENA), 64'd1);
        step();
        s_if.in_first__RDY = 1'b0;
        settle();
        send_beats(32'h100, 0, 6);

        // Asynchronous reset between edges at beat 7.
        #2;
        RST = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_out_ena", 64'(s_if.out_enq__ENA), 64'd0);
        check("arst_v", 64'(s_if.out_enq_v), 64'd0);
        check("arst_count", 64'(item_count), 64'd0);
        step();
        step();
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (s_if.out_enq__ENA || busy) seen++;
            step();
        end
        check("arst_no_old_beats", 64'(seen), 64'd0);

        // item_count wrap on a one-beat-per-item instance.
        RST_W = 1'b0;
        step();
        n = 0;
        for (int cyc = 0; cyc < 70000; cyc++) begin
            if (w_if.out_enq__ENA) begin
                n++;
                if (n == 65536) break;
            end
            step();
        end
        check("wrap_transfers", 64'(n), 64'd65536);
        check("wrap_count_ffff", 64'(item_count_w), 64'hFFFF);
        step();
        w_if.out_enq__RDY = 1'b0;
        settle();
        check("wrap_count_zero", 64'(item_count_w), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_out_serializer.md
FIFO_OUT_SERIALIZER -- requirements
Module: fifo_out_serializer

Interface
REQ-001 The block SHALL have parameter ITEM_W, default 768, giving the width of the upstream item in bits.
REQ-002 The block SHALL have parameter BEAT_W, default 32, giving the width of the downstream beat in bits; ITEM_W SHALL be an integer multiple of BEAT_W, with NBEATS = ITEM_W/BEAT_W (default 24).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 in_first  input  ITEM_W  head item of the upstream 1-entry FIFO.
REQ-006 in_first__RDY  input  1  in_first is valid.
REQ-007 in_deq__RDY  input  1  upstream FIFO can dequeue.
REQ-008 in_deq__ENA  output  1  dequeue strobe to the upstream FIFO.
REQ-009 out_enq__RDY  input  1  downstream sink can accept a beat.
REQ-010 out_enq__ENA  output  1  beat transfer strobe to the downstream sink.
REQ-011 out_enq_v  output  BEAT_W  beat data.
REQ-012 out_last  output  1  current beat is the final beat of an item.
REQ-013 abort  input  1  discard the remaining beats of the current item.
REQ-014 busy  output  1  an item is held and not fully sent.
REQ-015 item_count  output  16  number of items whose last beat has transferred, modulo 2^16.

Function
REQ-016 The FSM SHALL have two states: IDLE (no item held) and SEND (item held in shift register sreg, beat counter bcnt in 0..NBEATS-1).
REQ-017 The load condition SHALL be in_first__RDY && in_deq__RDY && (state==IDLE || (last-beat transfer this cycle && !abort)).
REQ-018 in_deq__ENA SHALL be combinational and equal to the load condition; it SHALL never be asserted when in_deq__RDY is 0.
REQ-019 On load, sreg SHALL take in_first, bcnt SHALL become 0, and state SHALL become SEND at the next edge.
REQ-020 out_enq__ENA SHALL be combinational and equal to (state==SEND && out_enq__RDY && !abort).
REQ-021 out_enq_v SHALL equal sreg[BEAT_W-1:0]; beats SHALL be sent LSB-first, so beat k carries item bits [k*BEAT_W +: BEAT_W].
REQ-022 On each beat transfer that is not the last beat, sreg SHALL shift right by BEAT_W with zero fill, and bcnt SHALL increment by 1.
REQ-023 out_last SHALL be 1 exactly when state==SEND and bcnt==NBEATS-1.
REQ-024 On the last-beat transfer, item_count SHALL increment by 1 and wrap from 0xFFFF to 0.
REQ-025 On the last-beat transfer, state SHALL be SEND if a load occurs in that cycle (back-to-back, no idle cycle between items), else IDLE.
REQ-026 While out_enq__RDY is 0 in SEND, sreg, bcnt and state SHALL hold and out_enq_v SHALL stay stable.
REQ-027 Latency SHALL be one cycle: an item dequeued at edge N SHALL present beat 0 in the cycle after N.
REQ-028 Sustained throughput SHALL be one item per NBEATS cycles when both sides are always ready.
REQ-029 abort in SEND SHALL force state to IDLE and bcnt to 0 at the next edge with no beat transfer that cycle; item_count SHALL be unchanged.
REQ-030 abort SHALL suppress any load in that cycle, including a pending back-to-back load.
REQ-031 abort in IDLE SHALL have no effect.
REQ-032 busy SHALL equal (state==SEND).

Reset
REQ-033 While RST is high, state SHALL be IDLE, sreg 0, bcnt 0 and item_count 0, taking effect immediately without waiting for a clock edge.
REQ-034 During reset, in_deq__ENA, out_enq__ENA, out_last and busy SHALL be 0, and out_enq_v SHALL be 0.
REQ-035 RST asserted mid-item SHALL discard the item, and no further beats of it SHALL be emitted after release.
REQ-036 After RST deasserts, the first load SHALL be possible on the first rising edge.

Verification
REQ-037 Single item: in_first = {24 words 0x00..0x17, word k = k}, sink always ready -> in_deq__ENA high for 1 cycle; out_enq_v = 0,1,...,0x17 on 24 consecutive cycles; out_last only on 0x17; item_count = 1.
REQ-038 Back-to-back: two items A and B queued, sink always ready -> A's beat 23 and B's beat 0 on adjacent cycles; in_deq__ENA pulses on the cycle of A's last beat; item_count = 2 after 48 beats.
REQ-039 Backpressure: out_enq__RDY low for 5 cycles at beat 3 -> out_enq_v holds at beat 3's value and bcnt holds at 3; the stream resumes with no lost or duplicated beat.
REQ-040 Abort: abort pulsed at beat 10 -> no beat transfers that cycle; busy = 0 next cycle; item_count unchanged; the next item starts at beat 0.
REQ-041 Reset mid-item: RST asserted asynchronously between edges at beat 7 -> busy and out_enq__ENA drop immediately; after release, no beats of the old item appear.
REQ-042 Wrap: 65536 items of 24 beats each -> item_count returns to 0x0000.
